fib_index_finder: RTL and testbench
===================================

Name: fib_index_finder

Overview:
- Inverse of the team's Fibonacci sequence generator.
- Takes a 20-bit value and reports whether it is a Fibonacci number and its sequence index. When it is not, it reports the index of the first term that exceeds it.
- Computes the sequence iteratively, one term per clock, with the same index convention as the generator: F(0)=0, F(1)=1, F(2)=1, F(3)=2, and so on.
- Sits downstream of the generator as a checker, or standalone behind a start/done handshake.

Parameters:
WIDTH, 20, bit width of the input value (matches the generator output width)
IDX_WIDTH, 8, bit width of the reported index (matches the generator user_input width)

Ports:
clock  input  1  single system clock; all logic on the rising edge
reset  input  1  synchronous, active-low reset; sampled on the rising edge of clock
start  input  1  request; sampled only in IDLE
value  input  WIDTH  number to classify; latched on the accepted start
busy  output  1  high from the edge after start is accepted until the block is back in IDLE
done  output  1  one-cycle pulse when the result is valid
is_fib  output  1  1 = value is a Fibonacci number
fib_index  output  IDX_WIDTH  if is_fib=1, smallest n with F(n)=value; otherwise smallest n with F(n)>value

Behaviour:
- Reset (reset=0 at a rising edge):
  - state=IDLE.
  - busy=0, done=0, is_fib=0, fib_index=0.
  - Internal terms cleared.
  - Applies from any state, including mid-SEARCH; the search in progress is abandoned and no done is produced.
- Internal registers:
  - target (WIDTH).
  - a and b, each WIDTH+2 bits. At least WIDTH+2 is needed because F(32)=2178309 must not wrap.
  - k (IDX_WIDTH).
  - a holds F(k) and b holds F(k+1).
- FSM states: IDLE, SEARCH, DONE.
- IDLE:
  - If start=1: target<=value, a<=0, b<=1, k<=0, busy<=1, go to SEARCH.
  - If start=0: stay in IDLE.
- SEARCH: one comparison per cycle.
  - a==target: is_fib<=1, fib_index<=k, go to DONE.
  - a>target (unsigned, full WIDTH+2 compare): is_fib<=0, fib_index<=k, go to DONE.
  - Otherwise: a<=b, b<=a+b, k<=k+1, stay in SEARCH.
- DONE:
  - done=1 for exactly this one cycle; busy stays 1.
  - Unconditionally go to IDLE next cycle, where busy<=0.
- Value 1 matches at k=1 (the smallest index), never at k=2.
- Latency, with edge 0 being the edge that accepts start:
  - Found at index n: done is high after edge n+2.
  - Not found with first exceeding index m: done is high after edge m+2.
  - Worst case is value=2^WIDTH-1: m=31, so done at edge 33.
- start is ignored while busy=1 (SEARCH and DONE).
  - start held high continuously re-launches in the IDLE cycle after DONE.
  - Back-to-back requests are therefore spaced by latency+1 cycles.
- value changes after acceptance have no effect on the running search.
- is_fib and fib_index hold their last result until the next result is written; they are not cleared on start.
- fib_index never overflows for the default parameters (maximum 31). For non-default WIDTH, IDX_WIDTH must cover the maximum index; otherwise behaviour is undefined.
- No combinational path from any input to any output; all outputs are registered.

Test Plan:
- Reset: hold reset=0 for 3 edges with start=1 -> busy=0, done=0, is_fib=0, fib_index=0; no search starts.
- Fibonacci value: value=5, start pulsed 1 cycle -> done pulse after edge 7, is_fib=1, fib_index=5, busy high after edges 1..7, low after edge 8.
- Boundaries:
  - value=0 -> done at edge 2, is_fib=1, index=0.
  - value=1 -> done at edge 3, is_fib=1, index=1.
  - value=832040 -> is_fib=1, index=30.
- Non-Fibonacci values:
  - value=4 -> done at edge 7, is_fib=0, index=5.
  - value=1048575 -> done at edge 33, is_fib=0, index=31; no wrap.
- Handshake:
  - start re-asserted with value=8 during SEARCH for value=13 -> ignored; result is is_fib=1, index=7.
  - start held high continuously -> exactly one done per search, requests spaced by latency+1 cycles.
- Reset mid-search: value=832040, drive reset=0 at edge 10 -> busy=0 next cycle, no done pulse. A subsequent start with value=21 -> is_fib=1, index=8.

Source files
------------

// File: rtl/fib_index_finder.sv
// fib_index_finder
//   Classifies a WIDTH-bit value against the Fibonacci sequence
//   F(0)=0, F(1)=1, F(2)=1, F(3)=2, ...
//   The sequence is stepped one term per clock. The result is:
//     is_fib=1, fib_index = smallest n with F(n) == value, or
//     is_fib=0, fib_index = smallest n with F(n) >  value.
//
// Ports
//   clock     : system clock, rising edge
//   reset     : synchronous active-low reset
//   start     : request, sampled only in IDLE
//   value     : number to classify, latched when start is accepted
//   busy      : high from the edge after acceptance until the block is back in IDLE
//   done      : one-cycle result-valid pulse
//   is_fib    : value is a Fibonacci number
//   fib_index : matching or first-exceeding index
//
// Timing (edge 0 accepts start)
//   The search compares F(k) against the target at edges 1..n+1.
//   At edge n+1 the result is written and the FSM moves to DONE.
//   DONE raises the registered done at edge n+2 and returns to IDLE.
//   busy is cleared only by IDLE's own update at edge n+3. As a result,
//   a start held high is accepted again at edge n+3 with no gap in busy.
module fib_index_finder #(
  parameter int WIDTH     = 20,
  parameter int IDX_WIDTH = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic [WIDTH-1:0]     value,
  output logic                 busy,
  output logic                 done,
  output logic                 is_fib,
  output logic [IDX_WIDTH-1:0] fib_index
);

  typedef enum logic [1:0] {IDLE, SEARCH, DONE} state_t;

  state_t                 state;
  logic [WIDTH-1:0]       target;
  // The terms are two bits wider than the input. The first term above
  // 2^WIDTH-1 must not wrap, and neither must the look-ahead sum b.
  logic [WIDTH+1:0]       a, b;
  logic [IDX_WIDTH-1:0]   k;
  logic [WIDTH+1:0]       target_x;

  assign target_x = {2'b00, target};

  always_ff @(posedge clock) begin
    if (!reset) begin
      state     <= IDLE;
      target    <= '0;
      a         <= '0;
      b         <= '0;
      k         <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      is_fib    <= 1'b0;
      fib_index <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            target <= value;
            a      <= '0;
            b      <= (WIDTH+2)'(1);
            k      <= '0;
            busy   <= 1'b1;
            state  <= SEARCH;
          end else begin
            busy   <= 1'b0;
          end
        end
        SEARCH: begin
          if (a == target_x) begin
            is_fib    <= 1'b1;
            fib_index <= k;
            state     <= DONE;
          end else if (a > target_x) begin
            is_fib    <= 1'b0;
            fib_index <= k;
            state     <= DONE;
          end else begin
            a <= b;
            b <= a + b;
            k <= k + IDX_WIDTH'(1);
          end
        end
        DONE: begin
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fib_index_finder.sv
// tb_fib_index_finder
//   Directed and random checks of fib_index_finder against a reference model.
//   The model is a precomputed table of Fibonacci terms, searched linearly.
module tb_fib_index_finder;

  localparam int WIDTH     = 20;
  localparam int IDX_WIDTH = 8;
  localparam int BOUND     = 80;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 start;
  logic [WIDTH-1:0]     value;
  logic                 busy, done, is_fib;
  logic [IDX_WIDTH-1:0] fib_index;

  int cmp  = 0;
  int errs = 0;
  longint fib [0:40];

  fib_index_finder #(.WIDTH(WIDTH), .IDX_WIDTH(IDX_WIDTH)) dut (
    .clock(clk), .reset(reset), .start(start), .value(value),
    .busy(busy), .done(done), .is_fib(is_fib), .fib_index(fib_index)
  );

  always #5 clk = ~clk;

  // Advance one rising edge, then sample 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    cmp++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: return the first table index whose term is >= v.
  // The value is a Fibonacci number exactly when that term equals v.
  task automatic ref_model(input int v, output bit f, output int n);
    n = 0;
    while (fib[n] < longint'(v)) n++;
    f = (fib[n] == longint'(v));
  endtask

  // Run one request with a one-cycle start pulse and check the whole transaction.
  task automatic run(input int v, input string tag);
    bit exp_f; int exp_n; int lat; bit busy_ok;
    ref_model(v, exp_f, exp_n);
    value = v[WIDTH-1:0];
    start = 1'b1;
    step();                       // edge 0
    start = 1'b0;
    lat = 0; busy_ok = 1'b1;
    do begin
      step();
      lat++;
      if (busy !== 1'b1) busy_ok = 1'b0;
    end while (done !== 1'b1 && lat < BOUND);
    check({tag, "_busy_during"}, {31'b0, busy_ok}, 1);
    check({tag, "_latency"},     lat, exp_n + 2);
    check({tag, "_is_fib"},      {31'b0, is_fib}, {31'b0, exp_f});
    check({tag, "_index"},       {24'b0, fib_index}, exp_n);
    step();
    check({tag, "_done_pulse"},  {31'b0, done}, 0);
    check({tag, "_busy_clear"},  {31'b0, busy}, 0);
    check({tag, "_index_hold"},  {24'b0, fib_index}, exp_n);
  endtask

  initial begin
    int dones; int first_d; int second_d; int third_d; int t; int v;
    fib[0] = 0; fib[1] = 1;
    for (int i = 2; i <= 40; i++) fib[i] = fib[i-1] + fib[i-2];

    // Hold reset for three edges with start asserted: no search may begin.
    reset = 1'b0; start = 1'b1; value = 20'd7;
    repeat (3) step();
    check("rst_busy",  {31'b0, busy}, 0);
    check("rst_done",  {31'b0, done}, 0);
    check("rst_isfib", {31'b0, is_fib}, 0);
    check("rst_index", {24'b0, fib_index}, 0);
    start = 1'b0; reset = 1'b1;
    step();
    check("rst_idle_busy", {31'b0, busy}, 0);

    // Directed values: ordinary cases, boundaries, and the worst case.
    run(5,       "v5");
    run(0,       "v0");
    run(1,       "v1");
    run(4,       "v4");
    run(832040,  "v832040");
    run(1048575, "vmax");
    run(2,       "v2");

    // A start pulse (and a new value) during SEARCH must be ignored.
    value = 20'd13; start = 1'b1;
    step();
    start = 1'b0;
    repeat (3) step();
    value = 20'd8; start = 1'b1;
    step();
    start = 1'b0;
    t = 4;
    while (done !== 1'b1 && t < BOUND) begin step(); t++; end
    check("ign_latency", t, 9);
    check("ign_is_fib",  {31'b0, is_fib}, 1);
    check("ign_index",   {24'b0, fib_index}, 7);
    step();

    // Start held high: 21 has index 8, so done is expected at edges 10, 21, 32.
    value = 20'd21; start = 1'b1;
    step();                       // edge 0
    dones = 0; first_d = -1; second_d = -1; third_d = -1;
    for (int e = 1; e <= 33; e++) begin
      step();
      if (done === 1'b1) begin
        dones++;
        if (first_d < 0) first_d = e;
        else if (second_d < 0) second_d = e;
        else if (third_d < 0) third_d = e;
      end
    end
    start = 1'b0;
    check("held_count", dones, 3);
    check("held_first", first_d, 10);
    check("held_space", second_d - first_d, 11);
    check("held_space2", third_d - second_d, 11);
    t = 0;
    while (busy !== 1'b0 && t < BOUND) begin step(); t++; end
    check("held_drain", {31'b0, busy}, 0);

    // Reset partway through a long search: no done may follow.
    value = 20'd832040; start = 1'b1;
    step();                       // edge 0
    start = 1'b0;
    repeat (9) step();            // edge 9
    reset = 1'b0;
    step();                       // edge 10
    check("mid_rst_busy", {31'b0, busy}, 0);
    reset = 1'b1;
    dones = 0;
    for (int e = 0; e < 40; e++) begin
      step();
      if (done === 1'b1) dones++;
    end
    check("mid_rst_nodone", dones, 0);
    run(21, "after_rst");

    // Random values, alternating between small values and the full range.
    for (int i = 0; i < 24; i++) begin
      if (i % 2 == 0) v = int'($urandom_range(0, 300));
      else            v = int'($urandom & 32'h000F_FFFF);
      run(v, $sformatf("rnd%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, errs);
    $finish;
  end

endmodule
